// File: rtl/cla_serial_addsub_if.sv
// Request/response bundle for the word-serial CLA add/subtract sequencer.
// The ovf signal exists only when CLA_OVF_EN is defined.
interface cla_serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, sub, out_ready,
`ifdef CLA_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
`ifdef CLA_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, result, cout
  );
endinterface

// File: rtl/cla_serial_addsub.sv
// Word-serial add/subtract: one 8-bit CLA slice per cycle with a registered inter-slice carry.
// Optional macro CLA_OVF_EN adds a registered signed-overflow flag (ovf).
module cla_serial_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_serial_addsub_if.slave    bus
);
  localparam int unsigned NSLICE = WIDTH / 8;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [7:0] sl_a, sl_b, sl_g, sl_p, sl_c, sl_sum;
  logic       sl_c7, sl_co;

  // 8-bit carry-lookahead slice; sl_c7 is the carry into bit 7, as the adder reports it.
  always_comb begin
    sl_a    = a_q[idx_q*8 +: 8];
    sl_b    = b_q[idx_q*8 +: 8];
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a ^ sl_b;
    sl_c    = '0;
    sl_c[0] = carry_q;
    for (int i = 0; i < 7; i++) begin
      sl_c[i+1] = sl_g[i] | (sl_p[i] & sl_c[i]);
    end
    sl_sum = sl_p ^ sl_c;
    sl_c7  = sl_c[7];
    // True slice carry-out rebuilt from the top bit and the carry into it.
    sl_co  = (sl_a[7] & sl_b[7]) | (sl_a[7] & sl_c7) | (sl_b[7] & sl_c7);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[idx_q*8 +: 8] = sl_sum;
        carry_d                = sl_co;
        if (idx_q == IdxW'(NSLICE - 1)) begin
          state_d = StDone;
          cout_d  = sl_co;
          ovf_d   = sl_c7 ^ sl_co;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
`ifdef CLA_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_cla_serial_addsub.sv
// Directed self-checking bench for cla_serial_addsub (WIDTH=32); ovf checks need CLA_OVF_EN.
module tb_cla_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc;

  always #5 clk = ~clk;

  cla_serial_addsub_if #(.WIDTH(32)) bus();

  cla_serial_addsub #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic s, input logic [31:0] exp_r, input logic exp_c);
    start(a, b, s);
    wait_done(tag, cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd4);
    check({tag, "_result"}, 64'(bus.result), 64'(exp_r));
    check({tag, "_cout"}, 64'(bus.cout), 64'(exp_c));
    finish_op();
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
`ifdef CLA_OVF_EN
    check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif

    op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    op("sub_7_5", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1);
    op("sub_5_7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0);
    op("add_mid", 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 32'h0001_FFFE, 1'b0);

    // Backpressure with a pending request held on the input.
    start(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done("bp", cyc);
    bus.in_valid = 1'b1;
    bus.a        = 32'h8000_0000;
    bus.b        = 32'h8000_0000;
    bus.sub      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_result", 64'(bus.result), 64'h2345_6789);
      check("bp_hold_cout", 64'(bus.cout), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_idle_valid", 64'(bus.out_valid), 64'd0);
    check("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_accept_in_ready", 64'(bus.in_ready), 64'd0);
    wait_done("bp2", cyc);
    check("bp2_latency", 64'(cyc), 64'd4);
    check("bp2_result", 64'(bus.result), 64'h0000_0000);
    check("bp2_cout", 64'(bus.cout), 64'd1);
    finish_op();

    // Reset while RUN is on slice 2.
    start(32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rrun_out_valid", 64'(bus.out_valid), 64'd0);
    check("rrun_in_ready", 64'(bus.in_ready), 64'd1);
    check("rrun_result", 64'(bus.result), 64'd0);
    check("rrun_cout", 64'(bus.cout), 64'd0);
    repeat (5) @(posedge clk);
    #1 check("rrun_no_output", 64'(bus.out_valid), 64'd0);
    op("post_rst_sub", 32'hFFFF_0000, 32'h0001_0000, 1'b1, 32'hFFFE_0000, 1'b1);

`ifdef CLA_OVF_EN
    op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
    check("ovf_pos_flag", 64'(bus.ovf), 64'd1);
    op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1);
    check("ovf_neg_flag", 64'(bus.ovf), 64'd1);
    op("ovf_small", 32'd5, 32'd7, 1'b0, 32'd12, 1'b0);
    check("ovf_small_flag", 64'(bus.ovf), 64'd0);
    op("ovf_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    check("ovf_wrap_flag", 64'(bus.ovf), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
